// File: rtl/tt_um_hoene_protocol_framer.sv
// Smart-LED protocol framer: counts bits/words, captures the leading own words, forwards the rest.
// Optional LED-count overflow test mode enabled by defining HOENE_FRAMER_TEST_MODE_EN.
module tt_um_hoene_protocol_framer #(
    parameter int unsigned BITS_PER_LED = 32,
    parameter int unsigned LED_CNT_W    = 12,
    parameter int unsigned OWN_LEDS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_clk,
    input  logic                          in_data,
    input  logic                          in_frame,
    output logic                          out_clk,
    output logic                          out_data,
    output logic                          out_frame,
    output logic [$clog2(BITS_PER_LED)-1:0] bit_counter,
    output logic [LED_CNT_W-1:0]          led_counter,
    output logic [BITS_PER_LED-1:0]       word_data,
    output logic [LED_CNT_W-1:0]          word_index,
    output logic                          word_valid,
    output logic                          test_mode,
    output logic                          frame_error
);

    localparam int unsigned BC_W = $clog2(BITS_PER_LED);

`ifdef HOENE_FRAMER_TEST_MODE_EN
    typedef enum logic [1:0] {IDLE, OWN, FWD, TEST} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN, FWD} state_t;
`endif

    state_t                  state, state_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BC_W-1:0]         bit_d;
    logic [LED_CNT_W-1:0]    led_d, word_index_d;
    logic [BITS_PER_LED-1:0] word_data_d;
    logic                    word_valid_d, out_clk_d, out_data_d, test_mode_d, frame_error_d;
    logic                    last_bit, led_max;

    assign last_bit = (bit_counter == BC_W'(BITS_PER_LED - 1));
    assign led_max  = &led_counter;

    // Next-state and next-output computation; everything is registered below.
    always_comb begin
        state_d       = state;
        shift_d       = shift_q;
        bit_d         = bit_counter;
        led_d         = led_counter;
        word_data_d   = word_data;
        word_index_d  = word_index;
        word_valid_d  = 1'b0;
        out_clk_d     = 1'b0;
        out_data_d    = 1'b0;
        test_mode_d   = 1'b0;
        frame_error_d = frame_error;

        if (!in_frame) begin
            state_d      = IDLE;
            shift_d      = '0;
            bit_d        = '0;
            led_d        = '0;
            word_data_d  = '0;
            word_index_d = '0;
            if (bit_counter != '0) frame_error_d = 1'b1;
        end else begin
            if (in_clk) begin
                bit_d = last_bit ? '0 : bit_counter + BC_W'(1);
                if (last_bit && !led_max) led_d = led_counter + LED_CNT_W'(1);
            end
            case (state)
                IDLE, OWN: begin
                    if (state == IDLE) frame_error_d = 1'b0;
                    state_d = OWN;
                    if (in_clk) begin
                        shift_d = {shift_q[BITS_PER_LED-2:0], in_data};
                        if (last_bit) begin
                            word_data_d  = {shift_q[BITS_PER_LED-2:0], in_data};
                            word_index_d = led_counter;
                            word_valid_d = 1'b1;
                            if (led_counter == LED_CNT_W'(OWN_LEDS - 1)) state_d = FWD;
                        end
                    end
                end
                FWD: begin
                    out_clk_d  = in_clk;
                    out_data_d = in_data;
`ifdef HOENE_FRAMER_TEST_MODE_EN
                    if (in_clk && last_bit && led_max) state_d = TEST;
`endif
                end
`ifdef HOENE_FRAMER_TEST_MODE_EN
                TEST: begin
                    out_clk_d  = in_clk;
                    out_data_d = in_data;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
`ifdef HOENE_FRAMER_TEST_MODE_EN
        test_mode_d = (state_d == TEST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_q     <= '0;
            bit_counter <= '0;
            led_counter <= '0;
            word_data   <= '0;
            word_index  <= '0;
            word_valid  <= 1'b0;
            out_clk     <= 1'b0;
            out_data    <= 1'b0;
            out_frame   <= 1'b0;
            test_mode   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_d;
            shift_q     <= shift_d;
            bit_counter <= bit_d;
            led_counter <= led_d;
            word_data   <= word_data_d;
            word_index  <= word_index_d;
            word_valid  <= word_valid_d;
            out_clk     <= out_clk_d;
            out_data    <= out_data_d;
            out_frame   <= in_frame;
            test_mode   <= test_mode_d;
            frame_error <= frame_error_d;
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_protocol_framer.sv
// Directed bench for the protocol framer: three instances (default, OWN_LEDS=3, LED_CNT_W=3) share stimulus.
module tb_tt_um_hoene_protocol_framer;

    logic clk = 1'b0;
    logic rst, in_clk, in_data, in_frame;
    always #5 clk = ~clk;

    logic a_oc, a_od, a_of, a_wv, a_tm, a_fe;
    logic [4:0] a_bit;
    logic [11:0] a_led, a_wi;
    logic [31:0] a_wd;
    logic b_oc, b_od, b_of, b_wv, b_tm, b_fe;
    logic [4:0] b_bit;
    logic [11:0] b_led, b_wi;
    logic [31:0] b_wd;
    logic c_oc, c_od, c_of, c_wv, c_tm, c_fe;
    logic [4:0] c_bit;
    logic [2:0] c_led, c_wi;
    logic [31:0] c_wd;

    tt_um_hoene_protocol_framer dut_a (
        .clk(clk), .rst(rst), .in_clk(in_clk), .in_data(in_data), .in_frame(in_frame),
        .out_clk(a_oc), .out_data(a_od), .out_frame(a_of), .bit_counter(a_bit),
        .led_counter(a_led), .word_data(a_wd), .word_index(a_wi), .word_valid(a_wv),
        .test_mode(a_tm), .frame_error(a_fe));

    tt_um_hoene_protocol_framer #(.OWN_LEDS(3)) dut_b (
        .clk(clk), .rst(rst), .in_clk(in_clk), .in_data(in_data), .in_frame(in_frame),
        .out_clk(b_oc), .out_data(b_od), .out_frame(b_of), .bit_counter(b_bit),
        .led_counter(b_led), .word_data(b_wd), .word_index(b_wi), .word_valid(b_wv),
        .test_mode(b_tm), .frame_error(b_fe));

    tt_um_hoene_protocol_framer #(.LED_CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .in_clk(in_clk), .in_data(in_data), .in_frame(in_frame),
        .out_clk(c_oc), .out_data(c_od), .out_frame(c_of), .bit_counter(c_bit),
        .led_counter(c_led), .word_data(c_wd), .word_index(c_wi), .word_valid(c_wv),
        .test_mode(c_tm), .frame_error(c_fe));

    int tests = 0;
    int fails = 0;

    // Observation: forwarded bits and captured words, sampled 1 ns after each edge.
    int a_fwd_n, b_fwd_n, c_fwd_n, a_wv_n, b_wv_n;
    logic [31:0] a_fwd, b_fwd, c_fwd;
    logic [31:0] a_words [4];
    logic [31:0] b_words [4];
    logic [11:0] a_idx [4];
    logic [11:0] b_idx [4];

    always @(posedge clk) begin
        #1;
        if (a_oc) begin a_fwd = {a_fwd[30:0], a_od}; a_fwd_n++; end
        if (b_oc) begin b_fwd = {b_fwd[30:0], b_od}; b_fwd_n++; end
        if (c_oc) begin c_fwd = {c_fwd[30:0], c_od}; c_fwd_n++; end
        if (a_wv) begin if (a_wv_n < 4) begin a_words[a_wv_n] = a_wd; a_idx[a_wv_n] = a_wi; end a_wv_n++; end
        if (b_wv) begin if (b_wv_n < 4) begin b_words[b_wv_n] = b_wd; b_idx[b_wv_n] = b_wi; end b_wv_n++; end
    end

    task automatic clear_mon();
        a_fwd_n = 0; b_fwd_n = 0; c_fwd_n = 0; a_wv_n = 0; b_wv_n = 0;
        a_fwd = '0; b_fwd = '0; c_fwd = '0;
    endtask

    task automatic start_frame();
        @(negedge clk); in_frame = 1'b1; in_clk = 1'b0; clear_mon();
        @(posedge clk); #2;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk); in_clk = 1'b1; in_data = w[i];
            @(posedge clk); #2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_clk = 1'b0; in_data = 1'b0;
            @(posedge clk); #2;
        end
    endtask

    task automatic end_frame();
        @(negedge clk); in_frame = 1'b0; in_clk = 1'b0; in_data = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        tests++; if ({a_oc, a_od, a_of, a_bit, a_led, a_wd, a_wi, a_wv, a_tm, a_fe} !== '0) begin fails++; $display("FAIL reset_a: got nonzero outputs wd=%h led=%h", a_wd, a_led); end
        tests++; if ({b_oc, b_od, b_of, b_bit, b_led, b_wd, b_wi, b_wv, b_tm, b_fe} !== '0) begin fails++; $display("FAIL reset_b: got nonzero outputs wd=%h led=%h", b_wd, b_led); end
        tests++; if ({c_oc, c_od, c_of, c_bit, c_led, c_wd, c_wi, c_wv, c_tm, c_fe} !== '0) begin fails++; $display("FAIL reset_c: got nonzero outputs wd=%h led=%h", c_wd, c_led); end
    endtask

    task automatic test_own_capture();
        start_frame();
        tests++; if (a_of !== 1'b1) begin fails++; $display("FAIL out_frame_rise: got %b want 1", a_of); end
        send_bits(32'hA5C3_0F1E, 32);
        send_bits(32'h1234_5678, 32);
        idle(1);
        tests++; if (a_wv_n !== 1) begin fails++; $display("FAIL own_wv_count: got %0d want 1", a_wv_n); end
        tests++; if (a_words[0] !== 32'hA5C3_0F1E) begin fails++; $display("FAIL own_word: got %h want a5c30f1e", a_words[0]); end
        tests++; if (a_idx[0] !== 12'd0) begin fails++; $display("FAIL own_index: got %0d want 0", a_idx[0]); end
        tests++; if (a_fwd_n !== 32) begin fails++; $display("FAIL fwd_count: got %0d want 32", a_fwd_n); end
        tests++; if (a_fwd !== 32'h1234_5678) begin fails++; $display("FAIL fwd_data: got %h want 12345678", a_fwd); end
        tests++; if ({a_led, a_bit} !== {12'd2, 5'd0}) begin fails++; $display("FAIL own_counters: got led=%0d bit=%0d want 2/0", a_led, a_bit); end
        end_frame();
        tests++; if ({a_fe, a_of, a_led} !== '0) begin fails++; $display("FAIL full_frame_end: got fe=%b of=%b led=%0d want 0", a_fe, a_of, a_led); end
    endtask

    task automatic test_multi_own();
        start_frame();
        send_bits(32'hCAFE_BABE, 32);
        send_bits(32'h0BAD_F00D, 32);
        send_bits(32'h8000_0001, 32);
        send_bits(32'h7E57_C0DE, 32);
        idle(1);
        tests++; if (b_wv_n !== 3) begin fails++; $display("FAIL multi_wv_count: got %0d want 3", b_wv_n); end
        tests++; if ({b_idx[0], b_idx[1], b_idx[2]} !== {12'd0, 12'd1, 12'd2}) begin fails++; $display("FAIL multi_index: got %0d %0d %0d want 0 1 2", b_idx[0], b_idx[1], b_idx[2]); end
        tests++; if ({b_words[0], b_words[1], b_words[2]} !== {32'hCAFE_BABE, 32'h0BAD_F00D, 32'h8000_0001}) begin fails++; $display("FAIL multi_words: got %h %h %h", b_words[0], b_words[1], b_words[2]); end
        tests++; if (b_fwd_n !== 32 || b_fwd !== 32'h7E57_C0DE) begin fails++; $display("FAIL multi_fwd: got %0d bits %h want 32 bits 7e57c0de", b_fwd_n, b_fwd); end
        tests++; if (b_led !== 12'd4) begin fails++; $display("FAIL multi_led: got %0d want 4", b_led); end
        end_frame();
    endtask

    task automatic test_truncated();
        start_frame();
        send_bits(32'hFFFF_0000, 32);
        send_bits(32'h0000_00FF, 8);
        end_frame();
        tests++; if (a_fe !== 1'b1) begin fails++; $display("FAIL trunc_set: got %b want 1", a_fe); end
        tests++; if ({a_bit, a_led} !== '0) begin fails++; $display("FAIL trunc_counters: got bit=%0d led=%0d want 0", a_bit, a_led); end
        idle(3);
        tests++; if (a_fe !== 1'b1) begin fails++; $display("FAIL trunc_sticky: got %b want 1", a_fe); end
        start_frame();
        tests++; if (a_fe !== 1'b0) begin fails++; $display("FAIL trunc_clear: got %b want 0", a_fe); end
        end_frame();
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        start_frame();
        for (int i = 0; i < 9; i++) begin
            w = 32'h0101_0101 * (i + 1);
            send_bits(w, 32);
            if (i == 7) begin
`ifdef HOENE_FRAMER_TEST_MODE_EN
                tests++; if (c_tm !== 1'b1) begin fails++; $display("FAIL ovf_test_mode: got %b want 1", c_tm); end
`else
                tests++; if (c_tm !== 1'b0) begin fails++; $display("FAIL ovf_test_mode: got %b want 0", c_tm); end
`endif
                tests++; if (c_led !== 3'd7) begin fails++; $display("FAIL ovf_led_sat: got %0d want 7", c_led); end
            end
        end
        idle(1);
        tests++; if (c_led !== 3'd7 || c_bit !== 5'd0) begin fails++; $display("FAIL ovf_led_hold: got led=%0d bit=%0d want 7/0", c_led, c_bit); end
        tests++; if (c_fwd_n !== 256 || c_fwd !== 32'h0909_0909) begin fails++; $display("FAIL ovf_fwd: got %0d bits %h want 256 bits 09090909", c_fwd_n, c_fwd); end
        tests++; if (a_tm !== 1'b0) begin fails++; $display("FAIL no_ovf_test_mode: got %b want 0", a_tm); end
        end_frame();
    endtask

    task automatic test_frame_end_strobe();
        start_frame();
        send_bits(32'h0F0F_0F0F, 32);
        send_bits(32'h0000_001F, 5);
        @(negedge clk); in_frame = 1'b0; in_clk = 1'b1; in_data = 1'b1;
        @(posedge clk); #2;
        tests++; if (a_oc !== 1'b0 || a_od !== 1'b0) begin fails++; $display("FAIL fes_forward: got clk=%b data=%b want 0/0", a_oc, a_od); end
        tests++; if ({a_bit, a_led} !== '0) begin fails++; $display("FAIL fes_counters: got bit=%0d led=%0d want 0", a_bit, a_led); end
        tests++; if (a_fe !== 1'b1) begin fails++; $display("FAIL fes_error: got %b want 1", a_fe); end
        @(negedge clk);
        @(posedge clk); #2;
        tests++; if ({a_bit, a_oc} !== '0) begin fails++; $display("FAIL idle_strobe: got bit=%0d oc=%b want 0", a_bit, a_oc); end
        idle(1);
    endtask

    task automatic test_async_reset();
        start_frame();
        send_bits(32'h0000_03FF, 10);
        @(negedge clk); in_clk = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if ({a_oc, a_od, a_of, a_bit, a_led, a_wd, a_wi, a_wv, a_tm, a_fe} !== '0) begin fails++; $display("FAIL async_reset: got bit=%0d of=%b want all 0", a_bit, a_of); end
        #1 rst = 1'b0;
        clear_mon();
        @(posedge clk); #2;
        send_bits(32'hDEAD_BEEF, 32);
        idle(1);
        tests++; if (a_wv_n !== 1 || a_words[0] !== 32'hDEAD_BEEF || a_idx[0] !== 12'd0) begin fails++; $display("FAIL post_reset_capture: got n=%0d word=%h idx=%0d want 1 deadbeef 0", a_wv_n, a_words[0], a_idx[0]); end
        end_frame();
    endtask

    initial begin
        rst = 1'b1; in_clk = 1'b0; in_data = 1'b0; in_frame = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        @(negedge clk); rst = 1'b0;
        idle(2);
        test_own_capture();
        test_multi_own();
        test_truncated();
        test_overflow();
        test_frame_end_strobe();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
